// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player: state encoding, note field
// widths, pitch limits and the transpose saturation helper.
package note_player_pkg;

  localparam int unsigned PITCH_W = 6;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned INSTR_W = 4;

  localparam logic [PITCH_W-1:0] PITCH_REST = 6'd0;
  localparam logic [PITCH_W-1:0] PITCH_MAX  = 6'd63;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_REQUEST_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC    = 3'd2;
  localparam logic [2:0] ST_PLAY_ENC    = 3'd3;

  typedef enum logic [2:0] {
    StIdle     = ST_IDLE_ENC,
    StRequest  = ST_REQUEST_ENC,
    StWaitNote = ST_WAIT_ENC,
    StPlay     = ST_PLAY_ENC
  } state_e;

  // Shift a pitch by a signed offset, saturating to 1..PITCH_MAX; rests stay rests.
  function automatic logic [PITCH_W-1:0] transpose_pitch(input logic [PITCH_W-1:0] note,
                                                         input logic signed [4:0]   shift);
    logic signed [7:0] sum;
    sum = $signed({2'b00, note}) + $signed({{3{shift[4]}}, shift});
    if (note == PITCH_REST) begin
      return PITCH_REST;
    end else if (sum < 8'sd1) begin
      return 6'd1;
    end else if (sum > 8'sd63) begin
      return PITCH_MAX;
    end
    return sum[PITCH_W-1:0];
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable note-duration down-counter. Decrements on tick while non-zero;
// a load takes priority over a coincident tick.
module note_timer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_remaining,
  output logic             o_done,
  output logic             o_in_gap
);

  logic [WIDTH-1:0] remaining_q;

  // Remaining-tick counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remaining_q <= '0;
    end else if (i_load) begin
      remaining_q <= i_load_val;
    end else if (i_tick && (remaining_q != '0)) begin
      remaining_q <= remaining_q - 1'b1;
    end
  end

  assign o_remaining = remaining_q;
  // This tick takes the count to zero.
  assign o_done      = i_tick && !i_load && (remaining_q == WIDTH'(1));
  assign o_in_gap    = (remaining_q <= WIDTH'(GAP_TICKS));

endmodule

// File: rtl/note_player.sv
// Note player: requests notes from the pattern sequencer, holds each for its
// length in frame ticks and drives gate/pitch/instrument to the voice stage.
// Optional macro NOTE_PLAYER_TRANSPOSE_EN adds a saturating pitch transpose input.
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned LEN_UNIT_TICKS = 6,
  parameter int unsigned GAP_TICKS      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_tick,
  output logic               o_note_stb,
  input  logic               i_note_valid,
  input  logic [PITCH_W-1:0] i_note,
  input  logic [LEN_W-1:0]   i_note_len,
  input  logic [INSTR_W-1:0] i_instrument,
`ifdef NOTE_PLAYER_TRANSPOSE_EN
  input  logic signed [4:0]  i_transpose,
`endif
  output logic               o_gate,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [INSTR_W-1:0] o_instrument,
  output logic               o_note_on,
  output logic               o_error
);

  localparam int unsigned REM_W = $clog2(32 * LEN_UNIT_TICKS + 1);

  state_e             state_q;
  logic [7:0]         wait_cnt_q;
  logic               capture;
  logic [REM_W-1:0]   load_val;
  logic [PITCH_W-1:0] capture_pitch;
  logic [REM_W-1:0]   remaining;
  logic               done;
  logic               in_gap;

  assign capture  = (state_q == StWaitNote) && i_enable && i_note_valid;
  assign load_val = REM_W'((32'(i_note_len) + 32'd1) * LEN_UNIT_TICKS);

`ifdef NOTE_PLAYER_TRANSPOSE_EN
  assign capture_pitch = transpose_pitch(i_note, i_transpose);
`else
  assign capture_pitch = i_note;
`endif

  note_timer #(
    .WIDTH     (REM_W),
    .GAP_TICKS (GAP_TICKS)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (capture),
    .i_load_val  (load_val),
    .i_tick      (i_tick && (state_q == StPlay)),
    .o_remaining (remaining),
    .o_done      (done),
    .o_in_gap    (in_gap)
  );

  // Request/play sequencing with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      o_note_stb   <= 1'b0;
      o_gate       <= 1'b0;
      o_pitch      <= PITCH_REST;
      o_instrument <= '0;
      o_note_on    <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_note_stb <= 1'b0;
      o_note_on  <= 1'b0;
      o_error    <= 1'b0;
      case (state_q)
        StIdle: begin
          o_gate <= 1'b0;
          if (i_enable) begin
            state_q    <= StRequest;
            o_note_stb <= 1'b1;
          end
        end
        StRequest: begin
          o_gate     <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= StWaitNote;
        end
        StWaitNote: begin
          o_gate <= 1'b0;
          if (!i_enable) begin
            state_q <= StIdle;
          end else if (i_note_valid) begin
            o_pitch      <= capture_pitch;
            o_instrument <= i_instrument;
            o_note_on    <= (capture_pitch != PITCH_REST);
            state_q      <= StPlay;
          end else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            o_error <= 1'b1;
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StPlay: begin
          if (!i_enable) begin
            o_gate  <= 1'b0;
            state_q <= StIdle;
          end else begin
            // Gate follows the count one cycle late; released for the final gap ticks.
            o_gate <= (o_pitch != PITCH_REST) && (remaining != '0) && !in_gap;
            if (done) begin
              state_q    <= StRequest;
              o_note_stb <= 1'b1;
            end
          end
        end
        default: begin
          o_gate  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: scoreboarded note captures plus gate,
// strobe, timeout, disable and reset scenarios.
module tb_note_player;
  import note_player_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_tick = 1'b0;
  logic       o_note_stb;
  logic       i_note_valid = 1'b0;
  logic [5:0] i_note = '0;
  logic [4:0] i_note_len = '0;
  logic [3:0] i_instrument = '0;
`ifdef NOTE_PLAYER_TRANSPOSE_EN
  logic signed [4:0] i_transpose = '0;
`endif
  logic       o_gate;
  logic [5:0] o_pitch;
  logic [3:0] o_instrument;
  logic       o_note_on;
  logic       o_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] pitch;
    logic [3:0] instr;
    logic       note_on;
  } exp_t;

  exp_t exp_q[$];

  note_player dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_tick       (i_tick),
    .o_note_stb   (o_note_stb),
    .i_note_valid (i_note_valid),
    .i_note       (i_note),
    .i_note_len   (i_note_len),
    .i_instrument (i_instrument),
`ifdef NOTE_PLAYER_TRANSPOSE_EN
    .i_transpose  (i_transpose),
`endif
    .o_gate       (o_gate),
    .o_pitch      (o_pitch),
    .o_instrument (o_instrument),
    .o_note_on    (o_note_on),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  // Reference model of the latched pitch.
  function automatic logic [5:0] model_pitch(input logic [5:0] note, input int shift);
    int s;
    if (note == 6'd0) return 6'd0;
    s = int'(note) + shift;
    if (s < 1) s = 1;
    if (s > 63) s = 63;
    return 6'(s);
  endfunction

  task automatic do_tick();
    i_tick = 1'b1;
    @(negedge i_clk);
    i_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge i_clk);
      do_tick();
    end
  endtask

  task automatic wait_stb(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (o_note_stb) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Sequencer response: called at the negedge where a strobe is visible.
  task automatic respond(input int delay, input logic [5:0] note, input logic [4:0] len,
                         input logic [3:0] instr, input int shift);
    exp_t e;
    repeat (delay) @(negedge i_clk);
    i_note       = note;
    i_note_len   = len;
    i_instrument = instr;
    i_note_valid = 1'b1;
    e.pitch      = model_pitch(note, shift);
    e.instr      = instr;
    e.note_on    = (e.pitch != 6'd0);
    exp_q.push_back(e);
    @(negedge i_clk);
    i_note_valid = 1'b0;
    i_note       = 6'h3f;
    i_note_len   = 5'h1f;
    i_instrument = 4'hf;
  endtask

  task automatic check_capture(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if ({o_pitch, o_instrument, o_note_on} !== {e.pitch, e.instr, e.note_on}) begin
      errors++;
      $display("FAIL %s: pitch/instr/note_on got %h/%h/%b want %h/%h/%b", name, o_pitch,
               o_instrument, o_note_on, e.pitch, e.instr, e.note_on);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_enable = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_note_stb, o_gate, o_pitch, o_instrument, o_note_on, o_error} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got stb=%b gate=%b pitch=%h instr=%h on=%b err=%b want 0",
               o_note_stb, o_gate, o_pitch, o_instrument, o_note_on, o_error);
    end
    i_enable = 1'b0;
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_note_stb !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_stb: got %b want 0", o_note_stb);
    end
  endtask

  task automatic test_note();
    bit seen;
    i_enable = 1'b1;
    wait_stb(4, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL first_stb: got none want strobe");
    end
    respond(3, 6'h15, 5'd3, 4'd2, 0);
    check_capture("note_capture");
    for (int t = 1; t <= 24; t++) begin
      repeat (2) @(negedge i_clk);
      checks++;
      if ({o_gate, o_note_stb} !== {(t <= 23), 1'b0}) begin
        errors++;
        $display("FAIL note_gate t=%0d: gate/stb got %b/%b want %b/0", t, o_gate, o_note_stb,
                 (t <= 23));
      end
      do_tick();
    end
    checks++;
    if (o_note_stb !== 1'b1) begin
      errors++;
      $display("FAIL stb_after_last_tick: got %b want 1", o_note_stb);
    end
  endtask

  task automatic test_rest();
    respond(2, 6'd0, 5'd0, 4'd5, 0);
    check_capture("rest_capture");
    for (int t = 1; t <= 6; t++) begin
      repeat (2) @(negedge i_clk);
      checks++;
      if ({o_gate, o_note_stb, o_note_on} !== 3'b000) begin
        errors++;
        $display("FAIL rest_quiet t=%0d: gate/stb/on got %b/%b/%b want 0/0/0", t, o_gate,
                 o_note_stb, o_note_on);
      end
      do_tick();
    end
    checks++;
    if (o_note_stb !== 1'b1) begin
      errors++;
      $display("FAIL rest_next_stb: got %b want 1", o_note_stb);
    end
  endtask

  task automatic test_timeout();
    int err_at;
    bit seen;
    err_at = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge i_clk);
      if (o_error) begin
        err_at = k;
        break;
      end
    end
    checks++;
    if (err_at != 16) begin
      errors++;
      $display("FAIL timeout_cycle: error at cycle %0d want 16", err_at);
    end
    wait_stb(2, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_restrobe: got none want strobe within 2");
    end
  endtask

  task automatic test_disable();
    int stbs;
    bit seen;
    respond(1, 6'h2a, 5'd3, 4'd7, 0);
    check_capture("disable_capture");
    run_ticks(9);
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_gate !== 1'b1) begin
      errors++;
      $display("FAIL disable_gate_before: got %b want 1", o_gate);
    end
    do_tick();
    i_enable = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_gate, o_pitch, o_instrument} !== {1'b0, 6'h2a, 4'd7}) begin
      errors++;
      $display("FAIL disable_hold: gate/pitch/instr got %b/%h/%h want 0/2a/7", o_gate, o_pitch,
               o_instrument);
    end
    stbs = 0;
    for (int i = 0; i < 40; i++) begin
      i_tick = (i % 4 == 0);
      @(negedge i_clk);
      if (o_note_stb) stbs++;
    end
    i_tick = 1'b0;
    checks++;
    if (stbs != 0) begin
      errors++;
      $display("FAIL disabled_stbs: got %0d want 0", stbs);
    end
    i_enable = 1'b1;
    wait_stb(3, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reenable_stb: got none want strobe");
    end
  endtask

`ifdef NOTE_PLAYER_TRANSPOSE_EN
  task automatic test_transpose();
    i_transpose = 5'sd15;
    respond(1, 6'd60, 5'd0, 4'd1, 15);
    check_capture("transpose_up_sat");
    run_ticks(6);
    i_transpose = -5'sd16;
    respond(1, 6'd5, 5'd0, 4'd1, -16);
    check_capture("transpose_down_sat");
    run_ticks(6);
    i_transpose = 5'sd15;
    respond(1, 6'd0, 5'd0, 4'd1, 15);
    check_capture("transpose_rest");
    run_ticks(6);
    i_transpose = 5'sd0;
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    respond(2, 6'h11, 5'd1, 4'd3, 0);
    check_capture("resetmid_capture");
    run_ticks(2);
    @(negedge i_clk);
    checks++;
    if (o_gate !== 1'b1) begin
      errors++;
      $display("FAIL resetmid_gate: got %b want 1", o_gate);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_note_stb, o_gate, o_pitch, o_instrument, o_note_on, o_error} !== 14'd0) begin
      errors++;
      $display("FAIL reset_in_play: got gate=%b pitch=%h instr=%h want all 0", o_gate, o_pitch,
               o_instrument);
    end
    i_rst = 1'b0;
    wait_stb(4, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL post_reset_stb: got none want strobe");
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    i_note = 6'h33;
    i_instrument = 4'd9;
    i_note_valid = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_note_stb, o_gate, o_pitch, o_instrument, o_note_on, o_error} !== 14'd0) begin
      errors++;
      $display("FAIL reset_in_wait: got pitch=%h instr=%h on=%b want all 0", o_pitch,
               o_instrument, o_note_on);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    i_note_valid = 1'b0;
    checks++;
    if ({o_pitch, o_instrument, o_note_on} !== 11'd0) begin
      errors++;
      $display("FAIL late_valid_ignored: got pitch=%h instr=%h on=%b want 0", o_pitch,
               o_instrument, o_note_on);
    end
    i_enable = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_note();
    test_rest();
    test_timeout();
    test_disable();
`ifdef NOTE_PLAYER_TRANSPOSE_EN
    test_transpose();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Consumer end of the pattern-sequencer note interface.
- Requests one note at a time with a strobe and captures the returned pitch, length and instrument.
- Holds the note for its duration, counted in frame ticks, then requests the next note.
- Drives gate, pitch and instrument to the downstream voice and oscillator stage.

Parameters:
- LEN_UNIT_TICKS, 6: i_tick pulses per note-length unit; range 1..255.
- GAP_TICKS, 1: release gap; gate deasserts for the final GAP_TICKS ticks of each note; range 0..LEN_UNIT_TICKS.
- TIMEOUT_CYCLES, 15: i_clk cycles to wait for i_note_valid after a strobe before aborting; range 1..255.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_enable  in  1  run/stop; level-sensitive
- i_tick  in  1  frame tick; 1-cycle pulse
- o_note_stb  out  1  note request to sequencer; 1-cycle pulse
- i_note_valid  in  1  note fields valid this cycle
- i_note  in  6  pitch; 0 = rest
- i_note_len  in  5  length code; duration = (code+1) units
- i_instrument  in  4  instrument index
- o_gate  out  1  voice gate
- o_pitch  out  6  current pitch (registered)
- o_instrument  out  4  current instrument (registered)
- o_note_on  out  1  1-cycle pulse on the first PLAY cycle of each non-rest note
- o_error  out  1  1-cycle pulse on response timeout

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. A reset mid-note drops o_gate on the next edge; no strobe is issued.
- State register is 3 bits. States: IDLE, REQUEST, WAIT_NOTE, PLAY.
- IDLE: if i_enable, next state is REQUEST.
- REQUEST: lasts exactly one cycle; o_note_stb = (state==REQUEST); next state is WAIT_NOTE.
- WAIT_NOTE: a timeout counter runs from 0.
  - On i_note_valid: latch i_note into o_pitch and i_instrument into o_instrument. Load remaining = (i_note_len+1)*LEN_UNIT_TICKS. Next state is PLAY.
  - If the counter reaches TIMEOUT_CYCLES without valid: pulse o_error and go to IDLE.
  - If i_enable drops: go to IDLE and discard any late valid.
- PLAY:
  - Each i_tick decrements remaining. A tick coinciding with the capture cycle is not counted.
  - o_gate = (o_pitch!=0) && (remaining > GAP_TICKS). Registered, so it updates the cycle after remaining changes.
  - o_note_on pulses on the first PLAY cycle only if pitch!=0.
  - When a tick brings remaining to 0: next state is REQUEST if i_enable, else IDLE.
- i_enable low in PLAY: o_gate goes 0 on the next edge and state goes to IDLE. o_pitch and o_instrument hold their values.
- i_note_valid outside WAIT_NOTE is ignored.
- Width of remaining: $clog2(32*LEN_UNIT_TICKS+1). No wrap is possible; decrement occurs only when remaining>0.
- Throughput: from the final tick to the next strobe is 1 cycle. The sequencer round-trip adds no tick loss when TIMEOUT_CYCLES is at least 4.

Optional Feature:
- Macro NOTE_PLAYER_TRANSPOSE_EN.
- When defined:
  - Adds port i_transpose, input, 5-bit signed, range -16..+15.
  - The latched pitch is i_note + i_transpose, saturated to 1..63.
  - Rests (i_note==0) are never transposed.
  - i_transpose is sampled only on the capture cycle.
- When undefined: the port is absent and the pitch is latched unchanged.

Decomposition:
- Package note_player_pkg holds:
  - the state encoding localparams;
  - field widths PITCH_W=6, LEN_W=5, INSTR_W=4;
  - PITCH_REST=0 and PITCH_MAX=63.
- One sub-module, note_timer: loadable down-counter with tick enable, providing remaining, done and in_gap outputs.

Test Plan:
- Defaults; enable; sequencer returns valid 4 cycles after strobe with pitch 0x15, len 3, instr 2:
  - o_note_on pulse; o_pitch=0x15; o_instrument=2;
  - o_gate high for 23 ticks and low for the 24th;
  - o_note_stb exactly 1 cycle after the 24th tick.
- Rest: pitch 0, len 0 -> o_gate stays 0, no o_note_on, next strobe after 6 ticks.
- Timeout: valid withheld -> o_error pulse 15 cycles after WAIT_NOTE entry, state IDLE; because enable remains high, a new strobe follows within 2 cycles.
- Disable mid-note at tick 10 of 24 -> o_gate 0 next cycle, no further strobes, o_pitch held; re-enable -> a fresh strobe.
- Reset asserted during PLAY and during WAIT_NOTE -> all outputs 0 next cycle; a late i_note_valid is ignored.
- With NOTE_PLAYER_TRANSPOSE_EN, i_transpose=+15:
  - pitch 60 gives o_pitch=63;
  - with i_transpose=-16, pitch 5 gives o_pitch=1;
  - pitch 0 stays 0.
